// File: rtl/spi_master_seq.sv
// spi_master_seq: SPI master sequencer.
// Runs one DATA_W-bit frame for each accepted start request and drives one of
// NUM_SS active-low slave selects for the length of that frame. It raises a
// sticky SPIF, and it flags write collisions and aborted transfers.
//
// Optional feature: define SPI_BURST_EN to add burst_len[7:0]. burst_len is
// sampled with start, and the burst runs burst_len+1 frames back to back. The
// slave select stays low between frames. SPIF and reg_write_en occur once,
// after the last frame.
//
// Ports:
//   clk, rst      clock; asynchronous active-low reset
//   baud_tick     one strobe per SCK bit period from the BRG
//   spe, mstr     SPI enable / master mode from SPCR
//   start         SPDR-write request; ss_sel is sampled with it
//   spif_clr      clears SPIF
//   ss_n          active-low slave selects
//   idle          high in IDLE
//   shifter_en    high while bits are shifting (RUN)
//   spdr_rd_en    one-clock pulse in LOAD
//   spdr_wr_en    one-clock pulse in UPDATE
//   reg_write_en  SPSR write strobe in the final UPDATE
//   spif          sticky transfer-complete flag
//   wcol          pulse: start arrived while busy
//   abort         pulse: spe/mstr dropped mid-transfer
//   brg_clr       combinational baud generator clear
//   bit_cnt       bits shifted so far in the current frame
module spi_master_seq #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  localparam int SEL_W = (NUM_SS > 1) ? $clog2(NUM_SS) : 1,
  localparam int CNT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick,
  input  logic              spe,
  input  logic              mstr,
  input  logic              start,
  input  logic [SEL_W-1:0]  ss_sel,
`ifdef SPI_BURST_EN
  input  logic [7:0]        burst_len,
`endif
  input  logic              spif_clr,
  output logic [NUM_SS-1:0] ss_n,
  output logic              idle,
  output logic              shifter_en,
  output logic              spdr_rd_en,
  output logic              spdr_wr_en,
  output logic              reg_write_en,
  output logic              spif,
  output logic              wcol,
  output logic              abort,
  output logic              brg_clr,
  output logic [CNT_W-1:0]  bit_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_UPDATE} state_t;

  state_t             state_r, state_s;
  logic [SEL_W-1:0]   sel_r, sel_s;
  logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_s;
  logic               spif_r, spif_s;
  logic               wcol_s, abort_s, last_frame_s, link_ok_s;
  logic [NUM_SS-1:0]  ss_n_s;
  logic [NUM_SS-1:0]  ss_n_r;
  logic               idle_r, shifter_en_r, spdr_rd_en_r, spdr_wr_en_r;
  logic               reg_write_en_r, wcol_r, abort_r;
`ifdef SPI_BURST_EN
  logic [7:0]         frames_r, frames_s;
`endif

  // The transfer may continue only while the block is enabled and in master mode.
  assign link_ok_s = spe & mstr;

`ifdef SPI_BURST_EN
  assign last_frame_s = (frames_r == 8'd0);
`else
  assign last_frame_s = 1'b1;
`endif

  // Next-state, next-count, and one-clock status pulse decode.
  always_comb begin
    state_s   = state_r;
    sel_s     = sel_r;
    bit_cnt_s = bit_cnt_r;
    abort_s   = 1'b0;
`ifdef SPI_BURST_EN
    frames_s  = frames_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start && link_ok_s &&
            ({{(32-SEL_W){1'b0}}, ss_sel} < 32'(NUM_SS))) begin
          state_s   = ST_LOAD;
          sel_s     = ss_sel;
          bit_cnt_s = {CNT_W{1'b0}};
`ifdef SPI_BURST_EN
          frames_s  = burst_len;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        bit_cnt_s = {CNT_W{1'b0}};
        if (!link_ok_s) begin
          state_s = ST_IDLE;
          abort_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!link_ok_s) begin
          state_s   = ST_IDLE;
          abort_s   = 1'b1;
          bit_cnt_s = {CNT_W{1'b0}};
        end else if (baud_tick) begin
          // The tick that ends the last bit closes the frame; the counter never wraps.
          if (bit_cnt_r == CNT_W'(DATA_W - 1)) begin
            state_s   = ST_UPDATE;
            bit_cnt_s = {CNT_W{1'b0}};
          end else begin
            bit_cnt_s = bit_cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_UPDATE: begin
        if (last_frame_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_LOAD;
`ifdef SPI_BURST_EN
          frames_s = frames_r - 8'd1;
`endif
        end
      end
      default: begin
        state_s   = ST_IDLE;
        bit_cnt_s = {CNT_W{1'b0}};
      end
    endcase

    wcol_s = start && (state_r != ST_IDLE);

    // A completing frame sets SPIF even when a clear arrives in the same clock.
    if ((state_r == ST_UPDATE) && last_frame_s) begin
      spif_s = 1'b1;
    end else if (spif_clr) begin
      spif_s = 1'b0;
    end else begin
      spif_s = spif_r;
    end

    // Hold the selected slave low for every state except IDLE.
    for (int i = 0; i < NUM_SS; i++) begin
      ss_n_s[i] = !((state_s != ST_IDLE) && (sel_s == SEL_W'(i)));
    end
  end

  // State register. The outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      sel_r          <= {SEL_W{1'b0}};
      bit_cnt_r      <= {CNT_W{1'b0}};
      spif_r         <= 1'b0;
      wcol_r         <= 1'b0;
      abort_r        <= 1'b0;
      ss_n_r         <= {NUM_SS{1'b1}};
      idle_r         <= 1'b1;
      shifter_en_r   <= 1'b0;
      spdr_rd_en_r   <= 1'b0;
      spdr_wr_en_r   <= 1'b0;
      reg_write_en_r <= 1'b0;
`ifdef SPI_BURST_EN
      frames_r       <= 8'd0;
`endif
    end else begin
      state_r        <= state_s;
      sel_r          <= sel_s;
      bit_cnt_r      <= bit_cnt_s;
      spif_r         <= spif_s;
      wcol_r         <= wcol_s;
      abort_r        <= abort_s;
      ss_n_r         <= ss_n_s;
      idle_r         <= (state_s == ST_IDLE);
      shifter_en_r   <= (state_s == ST_RUN);
      spdr_rd_en_r   <= (state_s == ST_LOAD);
      spdr_wr_en_r   <= (state_s == ST_UPDATE);
`ifdef SPI_BURST_EN
      reg_write_en_r <= (state_s == ST_UPDATE) && (frames_s == 8'd0);
      frames_r       <= frames_s;
`else
      reg_write_en_r <= (state_s == ST_UPDATE);
`endif
    end
  end

  assign ss_n         = ss_n_r;
  assign idle         = idle_r;
  assign shifter_en   = shifter_en_r;
  assign spdr_rd_en   = spdr_rd_en_r;
  assign spdr_wr_en   = spdr_wr_en_r;
  assign reg_write_en = reg_write_en_r;
  assign spif         = spif_r;
  assign wcol         = wcol_r;
  assign abort        = abort_r;
  assign bit_cnt      = bit_cnt_r;
  assign brg_clr      = ~mstr | ~spe | (state_r == ST_IDLE);

endmodule
